vt52_vram_sched: RTL and testbench
==================================

Name: vt52_vram_sched

Overview:
- Single-port character RAM scheduler for the VT52 terminal, in the 80x24 text datapath between the terminal command engine and the video character fetch.
- Shares one synchronous RAM port among three requesters, in fixed priority:
  1. video fetch (hard deadline);
  2. buffered command-engine writes;
  3. a built-in fill engine used for clear-screen and erase-to-end operations.
- Guarantees write ordering relative to fills.

Parameters:
- COLS, 80, characters per row
- ROWS, 24, rows per screen
- ADDR_W, 11, RAM address width (COLS*ROWS must be ≤ 2**ADDR_W)
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥ 2)

Ports:
- clk  in  1  single clock, CLK_VIDEO domain
- reset  in  1  synchronous, active-high
- vid_req  in  1  video fetch strobe, one cycle per character
- vid_addr  in  ADDR_W  video fetch address
- vid_valid  out  1  fetched character valid
- vid_data  out  8  fetched character
- wr_valid  in  1  command write request
- wr_ready  out  1  write accepted when wr_valid&&wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  8  write character
- fill_start  in  1  fill command pulse
- fill_from  in  ADDR_W  first fill address, inclusive
- fill_to  in  ADDR_W  last fill address, inclusive
- fill_char  in  8  fill character (normally 0x20)
- fill_busy  out  1  fill pending or running
- fill_done  out  1  one-cycle completion pulse
- fill_err  out  1  sticky; set by an illegal fill range
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid one cycle after address

Behaviour:

Reset values:
- All outputs 0.
- FIFO empty; fill state IDLE; fill_err cleared.
- A reset mid-fill aborts the fill with no fill_done pulse.
- A reset drops FIFO contents.

Port grant (per cycle, fixed priority):
- If vid_req: ram_addr=vid_addr, ram_we=0.
- Else if the FIFO is non-empty: pop the head; ram_addr/ram_wdata from the entry; ram_we=1.
- Else if fill state is RUN: write fill_char at the fill counter; ram_we=1.
- Else: ram_addr holds its previous value, ram_we=0.
- RAM port outputs are combinational from the grant decision and registered state.

Video path:
- Video is never stalled.
- vid_req in cycle N gives vid_valid=1 in cycle N+2, with vid_data = ram_rdata captured at N+1 (fixed latency 2).
- Back-to-back vid_req yields back-to-back vid_valid.

Write FIFO:
- Depth FIFO_DEPTH.
- wr_ready = !full && !fill_busy.
- Simultaneous push and pop is legal, including when full (push blocked by ready, pop proceeds).
- Pointers wrap modulo FIFO_DEPTH.
- Occupancy counter width is clog2(FIFO_DEPTH)+1.

Fill FSM (states IDLE, DRAIN, RUN, DONE):
- IDLE:
  - fill_start with fill_from ≤ fill_to < COLS*ROWS: latch the range and char, fill_busy=1, go to DRAIN.
  - fill_start with an illegal range: set fill_err, pulse fill_done next cycle, perform no writes, stay IDLE.
- DRAIN:
  - wr_ready=0.
  - Wait until the FIFO is empty (all earlier writes committed), then go to RUN.
- RUN:
  - Counter starts at fill_from and increments only on cycles where the fill is granted the port.
  - After writing fill_to, go to DONE.
  - vid_req cycles stall the counter.
- DONE:
  - fill_done=1 for exactly one cycle, fill_busy=0, go to IDLE.
  - wr_ready reasserts in the same cycle.
- fill_start while fill_busy is ignored.
- A single-cell fill (from==to) performs exactly 1 write.

Ordering guarantee:
- Writes accepted before fill_start commit before any fill write.
- Writes accepted after fill_done commit after all fill writes.

Continuous vid_req:
- Starves writes and fill indefinitely; this is legal.
- The video timing generator guarantees blanking gaps.

Test Plan:
- Reset, then push writes (0x000,'A'), (0x04F,'B'), (0x77F,'C') with no vid_req → three ram_we cycles in order; FIFO empty; wr_ready=1.
- vid_req held for 10 cycles while 6 writes are offered → wr_ready drops after 4 accepts; zero ram_we during vid_req; vid_valid at N+2 for each fetch; the 4 queued writes then commit in order.
- fill_start from=80 to=159 char=0x20 with 2 writes already queued → 2 queued writes first, then 80 fill writes at 80..159; fill_done single pulse; wr_ready=0 throughout busy.
- fill in progress with vid_req every 3rd cycle → fill addresses contiguous, no skipped or duplicated address; fill_done after exactly 80 granted writes.
- fill_start from=100 to=50, then from=0 to=1920 → fill_err=1; fill_done pulses; no ram_we; a second fill_start while busy is ignored.
- Reset asserted mid-fill at address 120 → next cycle all outputs 0; no fill_done; a subsequent write commits normally.

Source files
------------

// File: rtl/vt52_vram_sched.sv
// Single-port character RAM scheduler: video fetch > queued command writes > fill engine.
// Fills drain earlier writes first and lock out new writes until the fill completes.
module vt52_vram_sched #(
   parameter int COLS       = 80,
   parameter int ROWS       = 24,
   parameter int ADDR_W     = 11,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_valid,
   output logic [7:0]        vid_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_from,
   input  logic [ADDR_W-1:0] fill_to,
   input  logic [7:0]        fill_char,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              fill_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);
   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int CW      = PW + 1;
   localparam int VID_LAT = 2;
   localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(COLS*ROWS);

   typedef enum logic [1:0] {IDLE, DRAIN, RUN, DONE} fstate_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_ent_t;

   wr_ent_t           fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [CW-1:0]     count;
   fstate_t           state;
   logic [ADDR_W-1:0] fcnt, fto, addr_q;
   logic [7:0]        fchar;
   logic [VID_LAT-1:0] vld_pipe;
   logic              full, push, grant_vid, grant_wr, grant_fill, legal;

   assign full       = (count == CW'(FIFO_DEPTH));
   assign fill_busy  = (state == DRAIN) || (state == RUN);
   assign wr_ready   = !reset && !full && !fill_busy;
   assign push       = wr_valid && wr_ready;
   assign grant_vid  = !reset && vid_req;
   assign grant_wr   = !reset && !vid_req && (count != '0);
   assign grant_fill = !reset && !vid_req && (count == '0) && (state == RUN);
   assign legal      = (fill_from <= fill_to) && ({1'b0, fill_to} < CELLS);

   always_comb begin
      ram_addr  = addr_q;
      ram_we    = 1'b0;
      ram_wdata = 8'h00;
      if (grant_vid) begin
         ram_addr = vid_addr;
      end else if (grant_wr) begin
         ram_addr  = fifo_mem[rptr].addr;
         ram_wdata = fifo_mem[rptr].data;
         ram_we    = 1'b1;
      end else if (grant_fill) begin
         ram_addr  = fcnt;
         ram_wdata = fchar;
         ram_we    = 1'b1;
      end
   end

   // Idle cycles keep the last address on the bus to avoid needless RAM toggling.
   always_ff @(posedge clk) begin
      if (reset) addr_q <= '0;
      else       addr_q <= ram_addr;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= '{addr: wr_addr, data: wr_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)     wptr <= wptr + PW'(1);
         if (grant_wr) rptr <= rptr + PW'(1);
         count <= count + CW'(push) - CW'(grant_wr);
      end
   end

   // Fixed two-cycle video latency: address at N, RAM data at N+1, registered at N+2.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         vid_data <= 8'h00;
      end else begin
         vld_pipe <= {vld_pipe[VID_LAT-2:0], grant_vid};
         if (vld_pipe[0]) vid_data <= ram_rdata;
      end
   end
   assign vid_valid = vld_pipe[VID_LAT-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         fcnt      <= '0;
         fto       <= '0;
         fchar     <= 8'h00;
         fill_done <= 1'b0;
         fill_err  <= 1'b0;
      end else begin
         fill_done <= 1'b0;
         case (state)
            IDLE: if (fill_start) begin
               if (legal) begin
                  fcnt  <= fill_from;
                  fto   <= fill_to;
                  fchar <= fill_char;
                  state <= DRAIN;
               end else begin
                  fill_err  <= 1'b1;
                  fill_done <= 1'b1;
               end
            end
            DRAIN: if (count == '0) state <= RUN;
            RUN: if (grant_fill) begin
               if (fcnt == fto) begin
                  state     <= DONE;
                  fill_done <= 1'b1;
               end else begin
                  fcnt <= fcnt + ADDR_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vt52_vram_sched.sv
// Bench for vt52_vram_sched: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations on the committed write stream.
module tb_vt52_vram_sched;
   localparam int COLS = 80, ROWS = 24, AW = 11, DEPTH = 4;

   logic          clk = 1'b0, reset = 1'b1;
   logic          vid_req = 0, wr_valid = 0, fill_start = 0;
   logic [AW-1:0] vid_addr = '0, wr_addr = '0, fill_from = '0, fill_to = '0;
   logic [7:0]    wr_data = '0, fill_char = '0, ram_rdata = '0;
   logic          vid_valid, wr_ready, fill_busy, fill_done, fill_err, ram_we;
   logic [7:0]    vid_data, ram_wdata;
   logic [AW-1:0] ram_addr;

   int checks = 0, failures = 0;
   int vcnt = 0, dcnt = 0, bwcnt = 0;

   always #5 clk = ~clk;

   vt52_vram_sched #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .fill_start(fill_start), .fill_from(fill_from), .fill_to(fill_to), .fill_char(fill_char),
      .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   // Synchronous RAM plus a log of every committed write.
   logic [7:0]    mem [2**AW];
   logic [AW-1:0] wa [$];
   logic [7:0]    wd [$];
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         wa.push_back(ram_addr);
         wd.push_back(ram_wdata);
      end
   end

   always @(negedge clk) begin
      if (!reset && vid_valid) vcnt++;
      if (!reset && fill_done) dcnt++;
      if (!reset && fill_busy && wr_ready) bwcnt++;
   end

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   // Reference model: pending writes as a queue, fill as phase + remaining range.
   typedef struct {logic [AW-1:0] a; logic [7:0] d;} ent_t;
   ent_t          mq [$];
   int            fph = 0;              // 0 idle, 1 waiting for queue empty, 2 filling, 3 finishing
   logic [AW-1:0] fcur, fend, last = '0;
   logic [7:0]    fch, e1, e2;
   bit            mdone = 0, merr = 0, v1 = 0, v2 = 0;
   logic [7:0]    mm [2**AW];

   function automatic void exp_port(output bit we, output logic [AW-1:0] a, output logic [7:0] d);
      we = 0; a = last; d = 8'h00;
      if (vid_req) a = vid_addr;
      else if (mq.size() > 0) begin we = 1; a = mq[0].a; d = mq[0].d; end
      else if (fph == 2) begin we = 1; a = fcur; d = fch; end
   endfunction

   always @(posedge clk) begin
      bit we, busy, rdy; logic [AW-1:0] a; logic [7:0] d; int sz;
      if (reset) begin
         mq.delete(); fph = 0; mdone = 0; merr = 0; v1 = 0; v2 = 0; last = '0;
      end else begin
         exp_port(we, a, d);
         sz = mq.size();
         busy = (fph == 1 || fph == 2);
         rdy = (sz < DEPTH) && !busy;
         v2 = v1; e2 = e1; v1 = vid_req; e1 = mm[vid_addr];
         if (we) mm[a] = d;
         last = a;
         if (!vid_req && sz > 0) void'(mq.pop_front());
         if (wr_valid && rdy) mq.push_back('{wr_addr, wr_data});
         mdone = 0;
         case (fph)
            0: if (fill_start) begin
               if (fill_from <= fill_to && int'(fill_to) < COLS*ROWS) begin
                  fph = 1; fcur = fill_from; fend = fill_to; fch = fill_char;
               end else begin
                  merr = 1; mdone = 1;
               end
            end
            1: if (sz == 0) fph = 2;
            2: if (we && !vid_req && sz == 0) begin
               if (fcur == fend) begin fph = 3; mdone = 1; end
               else fcur = fcur + 1'b1;
            end
            default: fph = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      bit we; logic [AW-1:0] a; logic [7:0] d;
      if (!reset) begin
         exp_port(we, a, d);
         chk("ram_we", ram_we, we);
         chk("ram_addr", ram_addr, a);
         if (we) chk("ram_wdata", ram_wdata, d);
         chk("wr_ready", wr_ready, (mq.size() < DEPTH) && !(fph == 1 || fph == 2));
         chk("fill_busy", fill_busy, (fph == 1 || fph == 2));
         chk("fill_done", fill_done, mdone);
         chk("fill_err", fill_err, merr);
         chk("vid_valid", vid_valid, v2);
         if (v2) chk("vid_data", vid_data, e2);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] dd);
      bit acc = 0;
      wr_valid = 1; wr_addr = a; wr_data = dd;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk); acc = wr_ready;
         step();
      end
      wr_valid = 0;
      chk("write_accept", acc, 1);
   endtask

   task automatic start_fill(input logic [AW-1:0] f, input logic [AW-1:0] t, input logic [7:0] c);
      fill_start = 1; fill_from = f; fill_to = t; fill_char = c;
      step();
      fill_start = 0;
   endtask

   task automatic wait_done(input int max);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk); seen = fill_done;
         step();
      end
      chk("fill_done_seen", seen, 1);
   endtask

   initial begin
      int k, d0, n;
      bit hit;
      for (int i = 0; i < 2**AW; i++) begin mem[i] = i[7:0] ^ 8'hA5; mm[i] = i[7:0] ^ 8'hA5; end
      repeat (3) step();
      reset = 0;
      @(negedge clk);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_vid_valid", vid_valid, 0);
      chk("rst_fill_busy", fill_busy, 0);
      chk("rst_fill_done", fill_done, 0);
      chk("rst_fill_err", fill_err, 0);
      step();

      // Three plain writes commit in order.
      wa.delete(); wd.delete();
      do_write(11'h000, "A"); do_write(11'h04F, "B"); do_write(11'h77F, "C");
      repeat (3) step();
      chk("t1_nwrites", wa.size(), 3);
      if (wa.size() == 3) begin
         chk("t1_a0", {wa[0], wd[0]}, {11'h000, 8'h41});
         chk("t1_a1", {wa[1], wd[1]}, {11'h04F, 8'h42});
         chk("t1_a2", {wa[2], wd[2]}, {11'h77F, 8'h43});
      end
      chk("t1_ready", wr_ready, 1);

      // Video burst starves writes; FIFO fills after four accepts.
      wa.delete(); wd.delete(); vcnt = 0; k = 0;
      for (int c = 0; c < 10; c++) begin
         vid_req = 1; vid_addr = AW'(c * 7);
         wr_valid = (k < 6); wr_addr = AW'(11'h100 + k); wr_data = 8'h30 + 8'(k);
         @(negedge clk);
         if (wr_valid && wr_ready) k++;
         step();
      end
      vid_req = 0; wr_valid = 0;
      chk("t2_accepts", k, 4);
      chk("t2_we_during_vid", wa.size(), 0);
      repeat (6) step();
      chk("t2_vcnt", vcnt, 10);
      chk("t2_nwrites", wa.size(), 4);
      for (int i = 0; i < 4 && i < wa.size(); i++)
         chk("t2_order", {wa[i], wd[i]}, {AW'(11'h100 + i), 8'h30 + 8'(i)});

      // Two queued writes, then a fill of row 1.
      wa.delete(); wd.delete(); d0 = dcnt; bwcnt = 0;
      vid_req = 1; vid_addr = 11'h005;
      wr_valid = 1; wr_addr = 11'h300; wr_data = 8'h61; step();
      wr_addr = 11'h301; wr_data = 8'h62; step();
      wr_valid = 0; vid_req = 0;
      start_fill(11'd80, 11'd159, 8'h20);
      wait_done(300);
      step();
      chk("t3_nwrites", wa.size(), 82);
      if (wa.size() == 82) begin
         chk("t3_w0", {wa[0], wd[0]}, {11'h300, 8'h61});
         chk("t3_w1", {wa[1], wd[1]}, {11'h301, 8'h62});
         hit = 0;
         for (int i = 0; i < 80; i++) if (wa[2+i] != AW'(80 + i) || wd[2+i] != 8'h20) hit = 1;
         chk("t3_fill_seq", hit, 0);
      end
      chk("t3_done_pulses", dcnt - d0, 1);
      chk("t3_ready_while_busy", bwcnt, 0);

      // Fill with video interleaved every third cycle.
      wa.delete(); wd.delete(); d0 = dcnt; hit = 0;
      start_fill(11'd80, 11'd159, 8'h2E);
      for (int c = 0; c < 400 && !hit; c++) begin
         vid_req = (c % 3 == 0); vid_addr = AW'(c);
         @(negedge clk); hit = fill_done;
         step();
      end
      vid_req = 0;
      chk("t4_done_seen", hit, 1);
      chk("t4_nwrites", wa.size(), 80);
      n = 0;
      for (int i = 0; i < wa.size(); i++) if (wa[i] != AW'(80 + i)) n++;
      chk("t4_contiguous", n, 0);
      chk("t4_done_pulses", dcnt - d0, 1);

      // Illegal ranges, then a start while busy is ignored.
      wa.delete(); wd.delete();
      start_fill(11'd100, 11'd50, 8'h20);
      @(negedge clk);
      chk("t5_done_rev", fill_done, 1);
      chk("t5_err_rev", fill_err, 1);
      step();
      start_fill(11'd0, 11'd1920, 8'h20);
      @(negedge clk);
      chk("t5_done_oob", fill_done, 1);
      chk("t5_busy_oob", fill_busy, 0);
      step(); step();
      chk("t5_no_writes", wa.size(), 0);
      start_fill(11'd0, 11'd9, 8'h41);
      start_fill(11'd500, 11'd600, 8'h42);
      wait_done(100);
      repeat (3) step();
      chk("t5_nwrites", wa.size(), 10);
      if (wa.size() == 10) chk("t5_last", {wa[9], wd[9]}, {11'd9, 8'h41});

      // Reset in the middle of a fill.
      start_fill(11'd0, 11'd199, 8'h2D);
      hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk);
         if (ram_we && ram_addr == 11'd120) hit = 1;
         else step();
      end
      chk("t6_reached_120", hit, 1);
      #1 reset = 1;
      step();
      reset = 0;
      d0 = dcnt;
      @(negedge clk);
      chk("t6_ram_we", ram_we, 0);
      chk("t6_ram_addr", ram_addr, 0);
      chk("t6_ram_wdata", ram_wdata, 0);
      chk("t6_fill_busy", fill_busy, 0);
      chk("t6_fill_done", fill_done, 0);
      chk("t6_fill_err", fill_err, 0);
      chk("t6_vid_valid", vid_valid, 0);
      step();
      repeat (5) step();
      chk("t6_no_done", dcnt - d0, 0);
      wa.delete(); wd.delete();
      do_write(11'h222, 8'h5A);
      repeat (2) step();
      chk("t6_nwrites", wa.size(), 1);
      if (wa.size() == 1) chk("t6_write", {wa[0], wd[0]}, {11'h222, 8'h5A});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
